// File: rtl/encoder_4x2_seq.sv
// Sequential 4-to-2 encoder: collects request strobes into a pending set and
// issues their indices one at a time, in fixed priority, over valid/ready.
module encoder_4x2_seq #(
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       out_ready,
  output logic [1:0] code,
  output logic       out_valid,
  output logic [3:0] pending,
  output logic       overflow,
  output logic       idle
);

  localparam int unsigned N_REQ  = 4;
  localparam int unsigned CODE_W = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CODE_W-1:0]  code_d;
  logic [N_REQ-1:0]   pending_d;
  logic [N_REQ-1:0]   clr;
  logic               overflow_d;
  logic               load;
  logic [CODE_W-1:0]  sel_idx;

  // Priority pick over the registered pending set; the last hit in the scan wins.
  always_comb begin
    sel_idx = '0;
    if (LSB_FIRST) begin
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (pending[i]) sel_idx = CODE_W'(i);
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (pending[i]) sel_idx = CODE_W'(i);
      end
    end
  end

  // Next state, code and pending update; a fresh req always beats a clear.
  always_comb begin
    state_d    = state_q;
    code_d     = code;
    clr        = '0;
    load       = (state_q == EMPTY) || out_ready;
    if (load) begin
      if (|pending) begin
        clr     = N_REQ'(1) << sel_idx;
        code_d  = sel_idx;
        state_d = HOLD;
      end else begin
        state_d = EMPTY;
      end
    end
    pending_d  = (pending & ~clr) | req;
    overflow_d = |(req & pending & ~clr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      code     <= '0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      state_q  <= state_d;
      code     <= code_d;
      pending  <= pending_d;
      overflow <= overflow_d;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign idle      = !out_valid && (pending == '0);

endmodule

// File: tb/tb_encoder_4x2_seq.sv
// Directed vector bench for encoder_4x2_seq: MSB-first instance via a table,
// LSB-first instance via a short hand-written sequence.
module tb_encoder_4x2_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       out_ready;

  logic [1:0] code0, code1;
  logic       vld0, vld1;
  logic [3:0] pend0, pend1;
  logic       ovf0, ovf1;
  logic       idle0, idle1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  encoder_4x2_seq #(.LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
    .code(code0), .out_valid(vld0), .pending(pend0), .overflow(ovf0), .idle(idle0)
  );

  encoder_4x2_seq #(.LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
    .code(code1), .out_valid(vld1), .pending(pend1), .overflow(ovf1), .idle(idle1)
  );

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       rdy;
    logic [1:0] code;
    logic       vld;
    logic [3:0] pend;
    logic       ovf;
    logic       idle;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [3:0] q, input logic rd,
                     input logic [1:0] c, input logic v, input logic [3:0] p,
                     input logic o, input logic i);
    vec_t e;
    e.rst_n = r; e.req = q; e.rdy = rd;
    e.code = c; e.vld = v; e.pend = p; e.ovf = o; e.idle = i;
    vecs.push_back(e);
  endtask

  task automatic check(input string name, input int idx, input logic [3:0] act,
                       input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%b required=%b", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] q, input logic rd);
    rst_n = r; req = q; out_ready = rd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; out_ready = 1'b0;

    //  rst  req      rdy    code  vld  pend     ovf  idle
    // reset
    add(0, 4'b0000, 0,  2'd0, 0, 4'b0000, 0, 1);
    // single request, two-edge latency
    add(1, 4'b0100, 1,  2'd0, 0, 4'b0100, 0, 0);
    add(1, 4'b0000, 1,  2'd2, 1, 4'b0000, 0, 0);
    add(1, 4'b0000, 1,  2'd2, 0, 4'b0000, 0, 1);
    // multi-hot, MSB-first back-to-back
    add(1, 4'b1011, 1,  2'd2, 0, 4'b1011, 0, 0);
    add(1, 4'b0000, 1,  2'd3, 1, 4'b0011, 0, 0);
    add(1, 4'b0000, 1,  2'd1, 1, 4'b0001, 0, 0);
    add(1, 4'b0000, 1,  2'd0, 1, 4'b0000, 0, 0);
    add(1, 4'b0000, 1,  2'd0, 0, 4'b0000, 0, 1);
    // backpressure with a request arriving during the stall
    add(1, 4'b1000, 0,  2'd0, 0, 4'b1000, 0, 0);
    add(1, 4'b0000, 0,  2'd3, 1, 4'b0000, 0, 0);
    add(1, 4'b0001, 0,  2'd3, 1, 4'b0001, 0, 0);
    add(1, 4'b0000, 0,  2'd3, 1, 4'b0001, 0, 0);
    add(1, 4'b0000, 0,  2'd3, 1, 4'b0001, 0, 0);
    add(1, 4'b0000, 0,  2'd3, 1, 4'b0001, 0, 0);
    add(1, 4'b0000, 1,  2'd0, 1, 4'b0000, 0, 0);
    add(1, 4'b0000, 1,  2'd0, 0, 4'b0000, 0, 1);
    // overflow on a pending bit; re-post of the held bit is not overflow
    add(1, 4'b1010, 0,  2'd0, 0, 4'b1010, 0, 0);
    add(1, 4'b0000, 0,  2'd3, 1, 4'b0010, 0, 0);
    add(1, 4'b0010, 0,  2'd3, 1, 4'b0010, 1, 0);
    add(1, 4'b0000, 0,  2'd3, 1, 4'b0010, 0, 0);
    add(1, 4'b1000, 0,  2'd3, 1, 4'b1010, 0, 0);
    add(1, 4'b0000, 1,  2'd3, 1, 4'b0010, 0, 0);
    add(1, 4'b0000, 1,  2'd1, 1, 4'b0000, 0, 0);
    add(1, 4'b0000, 1,  2'd1, 0, 4'b0000, 0, 1);
    // req on the bit being selected this edge keeps it pending
    add(1, 4'b0011, 1,  2'd1, 0, 4'b0011, 0, 0);
    add(1, 4'b0010, 1,  2'd1, 1, 4'b0011, 0, 0);
    add(1, 4'b0000, 1,  2'd1, 1, 4'b0001, 0, 0);
    add(1, 4'b0000, 1,  2'd0, 1, 4'b0000, 0, 0);
    add(1, 4'b0000, 1,  2'd0, 0, 4'b0000, 0, 1);
    // reset mid-operation discards everything including req
    add(1, 4'b1110, 0,  2'd0, 0, 4'b1110, 0, 0);
    add(1, 4'b0000, 0,  2'd3, 1, 4'b0110, 0, 0);
    add(0, 4'b1111, 1,  2'd0, 0, 4'b0000, 0, 1);
    add(1, 4'b0000, 1,  2'd0, 0, 4'b0000, 0, 1);
    add(1, 4'b0000, 1,  2'd0, 0, 4'b0000, 0, 1);

    for (int k = 0; k < vecs.size(); k++) begin
      step(vecs[k].rst_n, vecs[k].req, vecs[k].rdy);
      check("code",     k, {2'b00, code0}, {2'b00, vecs[k].code});
      check("valid",    k, {3'b000, vld0}, {3'b000, vecs[k].vld});
      check("pending",  k, pend0,          vecs[k].pend);
      check("overflow", k, {3'b000, ovf0}, {3'b000, vecs[k].ovf});
      check("idle",     k, {3'b000, idle0}, {3'b000, vecs[k].idle});
    end

    // LSB-first order for req=1011: codes 0, 1, 3
    step(1'b0, 4'b0000, 1'b1);
    check("lsb_reset_idle", 100, {3'b000, idle1}, 4'b0001);
    step(1'b1, 4'b1011, 1'b1);
    check("lsb_post_pend", 101, pend1, 4'b1011);
    check("lsb_post_vld",  101, {3'b000, vld1}, 4'b0000);
    step(1'b1, 4'b0000, 1'b1);
    check("lsb_code_a", 102, {2'b00, code1}, 4'd0);
    check("lsb_vld_a",  102, {3'b000, vld1}, 4'b0001);
    check("lsb_pend_a", 102, pend1, 4'b1010);
    step(1'b1, 4'b0000, 1'b1);
    check("lsb_code_b", 103, {2'b00, code1}, 4'd1);
    check("lsb_pend_b", 103, pend1, 4'b1000);
    step(1'b1, 4'b0000, 1'b1);
    check("lsb_code_c", 104, {2'b00, code1}, 4'd3);
    check("lsb_vld_c",  104, {3'b000, vld1}, 4'b0001);
    check("lsb_pend_c", 104, pend1, 4'b0000);
    step(1'b1, 4'b0000, 1'b1);
    check("lsb_vld_end",  105, {3'b000, vld1}, 4'b0000);
    check("lsb_idle_end", 105, {3'b000, idle1}, 4'b0001);
    check("lsb_code_end", 105, {2'b00, code1}, 4'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/encoder_4x2_seq.md
Name: encoder_4x2_seq

Overview:
- Sequential 4-to-2 encoder, the inverse of the team's 2x4 decoder.
- Collects one-hot or multi-hot request strobes into a pending register.
- Issues their 2-bit indices one at a time, in fixed priority order, over a valid/ready output handshake.
- Sits between interrupt/event sources and a consumer that needs a binary index, e.g. to feed back into decoder_2x4 select lines.

Parameters:
- LSB_FIRST, 0: priority order. 0 = bit 3 highest, bit 0 lowest; 1 = bit 0 highest, bit 3 lowest.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- req  input  4  request strobes; req[i]=1 in a cycle posts request i.
- out_ready  input  1  consumer accepts code this cycle when out_valid=1.
- code  output  2  binary index of the request being presented.
- out_valid  output  1  code is valid; held until accepted.
- pending  output  4  registered set of posted but not yet presented requests.
- overflow  output  1  one-cycle registered pulse: a request was posted while already pending.
- idle  output  1  combinational: out_valid=0 and pending=0.

Behaviour:
- Reset (rst_n=0 at a rising edge): pending=0, code=0, out_valid=0, overflow=0, FSM=EMPTY.
  - Reset overrides all other activity, including a handshake in progress.
  - req in a reset cycle is discarded.
- FSM has two states:
  - EMPTY: out_valid=0.
  - HOLD: out_valid=1; code is stable and pending excludes the held bit.
- "load" condition = (state==EMPTY) or (state==HOLD and out_ready=1).
- Selection on each edge where load is true:
  - If pending is nonzero: sel = highest-priority set bit of pending (per LSB_FIRST); code <= index of sel; state <= HOLD.
  - If pending is zero: state <= EMPTY; code keeps its last value.
- Pending update each edge: pending <= (pending & ~clr) | req.
  - clr is the one-hot of sel when a load selects a bit, else 0.
  - Selection uses only the registered pending value; req posted this cycle is not eligible until the next edge.
- Latency:
  - req[i] high at edge k with the block EMPTY gives pending[i]=1 after edge k and out_valid=1 with code=i after edge k+1.
  - Back-to-back: with out_ready=1 held, one code is issued per cycle.
- Handshake:
  - While out_valid=1 and out_ready=0, code and out_valid hold.
  - pending may still gain bits during the stall.
  - out_ready is ignored while out_valid=0.
- Simultaneous events:
  - req[i] in the same cycle that bit i is selected/cleared: req wins, and pending[i] stays 1. This is not an overflow.
  - req[i] while bit i is currently held in code and not yet accepted: pending[i] is set, and i is re-issued later. This is not an overflow.
- Overflow:
  - overflow <= |(req & pending & ~clr) on every edge; high for exactly one cycle per offending cycle.
  - The request is coalesced; no count is kept.
- Accept with pending empty: state <= EMPTY, out_valid <= 0 on the same edge.
- Multiple req bits in one cycle: all are posted and issued in priority order.

Test Plan:
1. Reset, then req=4'b0100 for one cycle, out_ready=1 -> two edges later out_valid=1, code=2; next edge out_valid=0, idle=1.
2. LSB_FIRST=0, req=4'b1011 for one cycle, out_ready=1 -> codes 3, 1, 0 on consecutive cycles, then out_valid=0.
3. Repeat scenario 2 with LSB_FIRST=1 -> code order 0, 1, 3.
4. Backpressure: out_ready=0 for 5 cycles with code=3 held, req=4'b0001 during the stall -> code stays 3 and pending=4'b0001; on out_ready=1, code=0 next cycle.
5. Overflow: pending=4'b0010 and out_valid=1 with code=3 unaccepted; pulse req=4'b0010 -> overflow=1 for one cycle, pending unchanged. Then pulse req=4'b1000 -> overflow stays 0.
6. Reset mid-operation: with out_valid=1 and pending=4'b0110, drive rst_n=0 for one edge with req=4'b1111 -> after that edge all outputs are 0 and idle=1; no code is issued afterward without new req.
